// File: rtl/pool_out_writer_pkg.sv
// Shared definitions for the pooled-output GB writer: default widths,
// FSM state encoding and small elaboration-time helpers.
package pool_out_writer_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_PE     = 16;
    localparam int DEF_GB_WIDTH   = 512;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_ROW_WIDTH  = 16;

    // Frame sequencing states; encodings are fixed so debug taps stay stable.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_e;

    // Number of pooled rows that fit into one GB word.
    function automatic int calc_pack(input int gb_width, input int num_pe, input int data_width);
        return gb_width / (num_pe * data_width);
    endfunction

    // Counter width able to index n items, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_out_writer_gb_wr_reg.sv
// Output register slice towards the global buffer. Holds one write word and
// its address; loads a new word, holds it under back-pressure, drains it on
// handshake.
//
// Handshake: a word transfers on any cycle where out_val && out_rdy are both 1
// at the rising clock edge. While out_val=1 and out_rdy=0, out_dat/out_addr
// are frozen. can_load tells the producer the slot is empty or draining this
// cycle, so a load and a drain may happen on the same edge.
module gb_wr_reg
    import pool_out_writer_pkg::*;
#(
    parameter int DAT_W  = DEF_GB_WIDTH,
    parameter int ADDR_W = DEF_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DAT_W-1:0]  load_dat,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              out_rdy,
    output logic              can_load,
    output logic              out_val,
    output logic [DAT_W-1:0]  out_dat,
    output logic [ADDR_W-1:0] out_addr
);

    logic              val_q,  val_d;
    logic [DAT_W-1:0]  dat_q,  dat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Slot is free when empty or when the held word leaves this cycle.
    assign can_load = !val_q || out_rdy;

    // Next-state of the slice: load wins, otherwise drain clears valid.
    always_comb begin
        val_d  = val_q;
        dat_d  = dat_q;
        addr_d = addr_q;
        if (load) begin
            val_d  = 1'b1;
            dat_d  = load_dat;
            addr_d = load_addr;
        end else if (val_q && out_rdy) begin
            val_d  = 1'b0;
        end
    end

    // Register the slot contents; reset empties it and zeroes the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            val_q  <= 1'b0;
            dat_q  <= '0;
            addr_q <= '0;
        end else begin
            val_q  <= val_d;
            dat_q  <= dat_d;
            addr_q <= addr_d;
        end
    end

    assign out_val  = val_q;
    assign out_dat  = dat_q;
    assign out_addr = addr_q;

endmodule

// File: rtl/pool_out_writer.sv
// Pooled-output writer: accepts pooled rows, applies optional ReLU, packs
// PACK rows per GB word and writes them to consecutive GB addresses starting
// at the frame base. Signals frame completion with a one-cycle Done pulse.
//
// Handshakes: a row transfers when POOLOUT_Val && POOLOUT_Rdy at the rising
// edge; a GB write transfers when OUTGB_Val && GBOUT_Rdy at the rising edge.
// POOLOUT_Rdy is only raised in RUN when the output slot can take a word.
module pool_out_writer
    import pool_out_writer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_PE     = DEF_NUM_PE,
    parameter int GB_WIDTH   = DEF_GB_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ROW_WIDTH  = DEF_ROW_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         CFG_Start,
    input  logic [ADDR_WIDTH-1:0]        CFG_BaseAddr,
    input  logic [ROW_WIDTH-1:0]         CFG_NumRow,
    input  logic                         CFG_Relu,
    input  logic [NUM_PE*DATA_WIDTH-1:0] POOLOUT_Dat,
    input  logic                         POOLOUT_Val,
    output logic                         POOLOUT_Rdy,
    output logic [GB_WIDTH-1:0]          OUTGB_Dat,
    output logic [ADDR_WIDTH-1:0]        OUTGB_Addr,
    output logic                         OUTGB_Val,
    input  logic                         GBOUT_Rdy,
    output logic                         OUTGB_Busy,
    output logic                         OUTGB_Done,
    output logic [1:0]                   dbg_state
);

    localparam int ROW_W = NUM_PE * DATA_WIDTH;
    localparam int PACK  = calc_pack(GB_WIDTH, NUM_PE, DATA_WIDTH);
    localparam int PCW   = cnt_width(PACK);
    localparam logic [PCW-1:0] PACK_LAST = PCW'(PACK - 1);

    wr_state_e             state_q,    state_d;
    logic [ADDR_WIDTH-1:0] base_q,     base_d;
    logic [ROW_WIDTH-1:0]  num_row_q,  num_row_d;
    logic                  relu_q,     relu_d;
    logic [GB_WIDTH-1:0]   pack_q,     pack_d;
    logic [PCW-1:0]        pack_cnt_q, pack_cnt_d;
    logic [ROW_WIDTH-1:0]  row_cnt_q,  row_cnt_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic                  done_q,     done_d;

    logic                  can_load;
    logic                  pool_rdy;
    logic                  accept;
    logic                  last_row;
    logic                  word_done;
    logic [ROW_W-1:0]      relu_row;
    logic [GB_WIDTH-1:0]   pack_fill;
    logic [ADDR_WIDTH-1:0] load_addr;

    // Per-element ReLU: negative elements become zero when enabled, no width growth.
    always_comb begin
        relu_row = POOLOUT_Dat;
        for (int e = 0; e < NUM_PE; e++) begin
            if (relu_q && POOLOUT_Dat[e*DATA_WIDTH + DATA_WIDTH - 1]) begin
                relu_row[e*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end

    // Row acceptance, lane insertion and word-completion detection.
    always_comb begin
        pool_rdy  = (state_q == ST_RUN) && can_load;
        accept    = POOLOUT_Val && pool_rdy;
        last_row  = (row_cnt_q == (num_row_q - ROW_WIDTH'(1)));
        word_done = accept && ((pack_cnt_q == PACK_LAST) || last_row);
        load_addr = base_q + word_cnt_q;
        pack_fill = pack_q;
        for (int l = 0; l < PACK; l++) begin
            if (PCW'(l) == pack_cnt_q) begin
                pack_fill[l*ROW_W +: ROW_W] = relu_row;
            end
        end
    end

    // Frame sequencing and counter updates.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_row_d  = num_row_q;
        relu_d     = relu_q;
        pack_d     = pack_q;
        pack_cnt_d = pack_cnt_q;
        row_cnt_d  = row_cnt_q;
        word_cnt_d = word_cnt_q;
        done_d     = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (CFG_Start) begin
                    base_d     = CFG_BaseAddr;
                    num_row_d  = CFG_NumRow;
                    relu_d     = CFG_Relu;
                    pack_d     = '0;
                    pack_cnt_d = '0;
                    row_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = (CFG_NumRow == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    row_cnt_d = row_cnt_q + ROW_WIDTH'(1);
                    if (word_done) begin
                        pack_d     = '0;
                        pack_cnt_d = '0;
                        word_cnt_d = word_cnt_q + ADDR_WIDTH'(1);
                    end else begin
                        pack_d     = pack_fill;
                        pack_cnt_d = pack_cnt_q + PCW'(1);
                    end
                    if (last_row) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (OUTGB_Val && GBOUT_Rdy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame without a Done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            num_row_q  <= '0;
            relu_q     <= 1'b0;
            pack_q     <= '0;
            pack_cnt_q <= '0;
            row_cnt_q  <= '0;
            word_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_row_q  <= num_row_d;
            relu_q     <= relu_d;
            pack_q     <= pack_d;
            pack_cnt_q <= pack_cnt_d;
            row_cnt_q  <= row_cnt_d;
            word_cnt_q <= word_cnt_d;
            done_q     <= done_d;
        end
    end

    gb_wr_reg #(
        .DAT_W  (GB_WIDTH),
        .ADDR_W (ADDR_WIDTH)
    ) u_gb_wr_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (word_done),
        .load_dat  (pack_fill),
        .load_addr (load_addr),
        .out_rdy   (GBOUT_Rdy),
        .can_load  (can_load),
        .out_val   (OUTGB_Val),
        .out_dat   (OUTGB_Dat),
        .out_addr  (OUTGB_Addr)
    );

    assign POOLOUT_Rdy = pool_rdy;
    assign OUTGB_Busy  = (state_q != ST_IDLE);
    assign OUTGB_Done  = done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pool_out_writer.sv
// Bench for pool_out_writer with 4 elements of 8 bits per row and 128-bit GB
// words (four rows per word). Expected GB writes go into a queue when a frame
// is issued; a monitor compares every presented write against the queue head.
module tb_pool_out_writer;

    localparam int DW   = 8;
    localparam int NPE  = 4;
    localparam int GBW  = 128;
    localparam int AW   = 12;
    localparam int RW   = 16;
    localparam int ROWW = NPE * DW;
    localparam int PACK = GBW / ROWW;
    localparam int EW   = AW + GBW;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            CFG_Start = 1'b0;
    logic [AW-1:0]   CFG_BaseAddr = '0;
    logic [RW-1:0]   CFG_NumRow = '0;
    logic            CFG_Relu = 1'b0;
    logic [ROWW-1:0] POOLOUT_Dat = '0;
    logic            POOLOUT_Val = 1'b0;
    logic            POOLOUT_Rdy;
    logic [GBW-1:0]  OUTGB_Dat;
    logic [AW-1:0]   OUTGB_Addr;
    logic            OUTGB_Val;
    logic            GBOUT_Rdy = 1'b1;
    logic            OUTGB_Busy;
    logic            OUTGB_Done;
    logic [1:0]      dbg_state;

    logic [EW-1:0]   exp_q[$];
    logic [ROWW-1:0] rows_buf [0:63];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int first_val_cyc = 0;
    int last_hs_cyc = 0;
    int done_cyc = 0;
    int done_total = 0;
    int exp_done = 0;
    bit bp_en = 1'b0;

    pool_out_writer #(
        .DATA_WIDTH (DW),
        .NUM_PE     (NPE),
        .GB_WIDTH   (GBW),
        .ADDR_WIDTH (AW),
        .ROW_WIDTH  (RW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .CFG_Start    (CFG_Start),
        .CFG_BaseAddr (CFG_BaseAddr),
        .CFG_NumRow   (CFG_NumRow),
        .CFG_Relu     (CFG_Relu),
        .POOLOUT_Dat  (POOLOUT_Dat),
        .POOLOUT_Val  (POOLOUT_Val),
        .POOLOUT_Rdy  (POOLOUT_Rdy),
        .OUTGB_Dat    (OUTGB_Dat),
        .OUTGB_Addr   (OUTGB_Addr),
        .OUTGB_Val    (OUTGB_Val),
        .GBOUT_Rdy    (GBOUT_Rdy),
        .OUTGB_Busy   (OUTGB_Busy),
        .OUTGB_Done   (OUTGB_Done),
        .dbg_state    (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end of test, required end within 500000 time units");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares each presented write to the queue head, pops on handshake
    task automatic monitor();
        logic val_prev;
        val_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (OUTGB_Val) begin
                    if (!val_prev) first_val_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL wr_unexpected: got write addr 0x%0h dat 0x%0h, required no write",
                                 OUTGB_Addr, OUTGB_Dat);
                    end else begin
                        chk("wr_word", {OUTGB_Addr, OUTGB_Dat}, exp_q[0]);
                        if (GBOUT_Rdy) begin
                            void'(exp_q.pop_front());
                            last_hs_cyc = cyc;
                        end
                    end
                    if (!GBOUT_Rdy) chk("pool_rdy_in_stall", EW'(POOLOUT_Rdy), EW'(0));
                end
                if (OUTGB_Done) done_total++;
            end
            val_prev = OUTGB_Val;
        end
    endtask

    // Random GB back-pressure when enabled
    task automatic backpressure();
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) GBOUT_Rdy = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Reference model: expected GB writes of one frame from rows_buf
    task automatic model_frame(input logic [AW-1:0] base, input int n, input bit relu);
        logic [GBW-1:0]  w;
        logic [ROWW-1:0] v;
        w = '0;
        for (int r = 0; r < n; r++) begin
            v = rows_buf[r];
            for (int e = 0; e < NPE; e++) begin
                if (relu && ($signed(v[e*DW +: DW]) < 0)) v[e*DW +: DW] = '0;
            end
            w[(r % PACK)*ROWW +: ROWW] = v;
            if ((r % PACK == PACK - 1) || (r == n - 1)) begin
                exp_q.push_back({AW'(int'(base) + r / PACK), w});
                w = '0;
            end
        end
    endtask

    task automatic start_frame(input logic [AW-1:0] base, input int n, input bit relu);
        CFG_BaseAddr = base;
        CFG_NumRow   = RW'(n);
        CFG_Relu     = relu;
        CFG_Start    = 1'b1;
        @(posedge clk);
        #1;
        CFG_Start    = 1'b0;
    endtask

    task automatic send_row(input logic [ROWW-1:0] d, input int gap);
        bit ok;
        ok = 1'b0;
        POOLOUT_Val = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        POOLOUT_Dat = d;
        POOLOUT_Val = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (POOLOUT_Rdy) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        POOLOUT_Val = 1'b0;
        chk("row_accepted", EW'(ok), EW'(1));
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (OUTGB_Done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end
        end
        chk({name, "_done"}, EW'(seen), EW'(1));
        exp_done++;
        @(posedge clk);
        #1;
        chk({name, "_done_width"}, EW'(OUTGB_Done), EW'(0));
        chk({name, "_drained"}, EW'(exp_q.size()), EW'(0));
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_val"},  EW'(OUTGB_Val),   EW'(0));
        chk({name, "_dat"},  EW'(OUTGB_Dat),   EW'(0));
        chk({name, "_addr"}, EW'(OUTGB_Addr),  EW'(0));
        chk({name, "_done"}, EW'(OUTGB_Done),  EW'(0));
        chk({name, "_busy"}, EW'(OUTGB_Busy),  EW'(0));
        chk({name, "_rdy"},  EW'(POOLOUT_Rdy), EW'(0));
    endtask

    initial begin
        fork
            monitor();
            backpressure();
        join_none

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_outputs_zero("reset");

        // 1: reset mid-frame after two rows aborts silently
        for (int r = 0; r < 8; r++) rows_buf[r] = $urandom;
        model_frame(12'h010, 8, 1'b0);
        start_frame(12'h010, 8, 1'b0);
        send_row(rows_buf[0], 0);
        send_row(rows_buf[1], 0);
        exp_q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_outputs_zero("abort");
        repeat (5) @(posedge clk);
        #1;

        // 2: four rows pack into one word
        exp_q.push_back({12'h010, 128'h100F0E0D_0C0B0A09_08070605_04030201});
        start_frame(12'h010, 4, 1'b0);
        send_row(32'h04030201, 0);
        send_row(32'h08070605, 0);
        send_row(32'h0C0B0A09, 0);
        send_row(32'h100F0E0D, 0);
        wait_done("t2");
        chk("t2_val_latency", EW'(first_val_cyc - acc_cyc), EW'(1));
        chk("t2_done_latency", EW'(done_cyc - last_hs_cyc), EW'(2));

        // 3: six rows -> full word plus half-filled word
        exp_q.push_back({12'h010, 128'h100F0E0D_0C0B0A09_08070605_04030201});
        exp_q.push_back({12'h011, 64'h0, 32'h18171615, 32'h14131211});
        start_frame(12'h010, 6, 1'b0);
        send_row(32'h04030201, 0);
        send_row(32'h08070605, 0);
        send_row(32'h0C0B0A09, 0);
        send_row(32'h100F0E0D, 0);
        send_row(32'h14131211, 0);
        send_row(32'h18171615, 0);
        wait_done("t3");

        // 4: GB stalls for 5 cycles while the first word is pending
        for (int r = 0; r < 8; r++) rows_buf[r] = $urandom;
        GBOUT_Rdy = 1'b0;
        model_frame(12'h010, 8, 1'b0);
        start_frame(12'h010, 8, 1'b0);
        fork
            begin
                for (int r = 0; r < 8; r++) send_row(rows_buf[r], 0);
            end
            begin
                bit seen_val;
                seen_val = 1'b0;
                for (int i = 0; i < 100 && !seen_val; i++) begin
                    @(negedge clk);
                    if (OUTGB_Val) seen_val = 1'b1;
                end
                chk("t4_first_word_pending", EW'(seen_val), EW'(1));
                repeat (5) @(posedge clk);
                #1;
                GBOUT_Rdy = 1'b1;
            end
        join
        wait_done("t4");

        // 5: ReLU on and off
        exp_q.push_back({12'h010, 96'h0, 32'h00007F01});
        start_frame(12'h010, 1, 1'b1);
        send_row(32'h80FF7F01, 0);
        wait_done("t5_relu");
        exp_q.push_back({12'h010, 96'h0, 32'h80FF7F01});
        start_frame(12'h010, 1, 1'b0);
        send_row(32'h80FF7F01, 0);
        wait_done("t5_norelu");

        // 6: empty frame, then a start pulse during RUN is ignored
        start_frame(12'h010, 0, 1'b0);
        wait_done("t6_empty");
        for (int r = 0; r < 3; r++) rows_buf[r] = $urandom;
        model_frame(12'h020, 3, 1'b1);
        start_frame(12'h020, 3, 1'b1);
        send_row(rows_buf[0], 0);
        CFG_BaseAddr = 12'h300;
        CFG_NumRow   = 16'd1;
        CFG_Relu     = 1'b0;
        CFG_Start    = 1'b1;
        @(posedge clk);
        #1;
        CFG_Start    = 1'b0;
        chk("t6_busy_after_start", EW'(OUTGB_Busy), EW'(1));
        send_row(rows_buf[1], 0);
        send_row(rows_buf[2], 0);
        wait_done("t6_ignore");

        // Random frames with back-pressure and row gaps, incl. address wrap
        bp_en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int n;
            bit relu;
            logic [AW-1:0] base;
            n    = $urandom_range(1, 11);
            relu = 1'($urandom_range(0, 1));
            base = (f == 0) ? 12'hFFE : AW'($urandom_range(0, 4095));
            for (int r = 0; r < n; r++) rows_buf[r] = $urandom;
            model_frame(base, n, relu);
            start_frame(base, n, relu);
            for (int r = 0; r < n; r++) send_row(rows_buf[r], $urandom_range(0, 2));
            wait_done("rand");
        end
        bp_en = 1'b0;
        GBOUT_Rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        chk("done_count", EW'(done_total), EW'(exp_done));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
